load_store_unit: RTL

Initiator side of the byte-organised data memory port. Accepts one load or store request per transaction from the pipeline and sequences it into 1, 2 or 4 single-byte memory beats, big-endian (lowest address = most significant byte). Loads are assembled with zero or sign extension into a 32-bit result. Sits between the execute stage and the data memory; the pipeline stalls on `busy`.

---
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Byte-serial load/store initiator: 1/2/4 big-endian byte beats per request, loads zero/sign-extended.
// Optional feature macro: LSU_ALIGN_CHECK_EN (reject misaligned half/word accesses with misalignErr).
module load_store_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              reqValid,
   output logic              reqReady,
   input  logic              reqWrite,
   input  logic [1:0]        reqSize,
   input  logic              reqSigned,
   input  logic [ADDR_W-1:0] reqAddr,
   input  logic [31:0]       reqWData,
   output logic [ADDR_W-1:0] memAddr,
   output logic              memRead,
   output logic              memWrite,
   output logic [7:0]        memWData,
   input  logic [7:0]        memRData,
   input  logic              memReady,
   output logic              respValid,
   output logic [31:0]       respData,
   output logic              misalignErr,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] base, base_n, mem_addr_n;
   logic [31:0]       data, data_n, resp_data_n;   // store operand, or load assembly register
   logic [1:0]        size, size_n, last, last_n, idx, idx_n, idx_inc, req_last;
   logic              sgn, sgn_n, wr, wr_n, err, err_n;
   logic              mem_read_n, mem_write_n, resp_valid_n, misalign_err_n, busy_n;
   logic [7:0]        mem_wdata_n;
   logic              misaligned;
   logic [31:0]       assembled;

   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] sel);
      logic [31:0] t;
      t = w >> {sel, 3'b000};
      return t[7:0];
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] a, input logic [1:0] sz, input logic s);
      case (sz)
         2'd0:    return {{24{s & a[7]}}, a[7:0]};
         2'd1:    return {{16{s & a[15]}}, a[15:0]};
         default: return a;
      endcase
   endfunction

   assign reqReady  = (state == IDLE) && resetN;
   assign req_last  = (reqSize == 2'd0) ? 2'd0 : (reqSize == 2'd1) ? 2'd1 : 2'd3;
   assign assembled = {data[23:0], memRData};
   assign idx_inc   = idx + 2'd1;

`ifdef LSU_ALIGN_CHECK_EN
   assign misaligned = (reqSize == 2'd1) ? reqAddr[0] : (reqSize[1] && (reqAddr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
      state_n        = state;
      base_n         = base;
      data_n         = data;
      size_n         = size;
      sgn_n          = sgn;
      wr_n           = wr;
      err_n          = err;
      last_n         = last;
      idx_n          = idx;
      mem_addr_n     = memAddr;
      mem_read_n     = memRead;
      mem_write_n    = memWrite;
      mem_wdata_n    = memWData;
      resp_valid_n   = 1'b0;
      resp_data_n    = respData;
      misalign_err_n = 1'b0;
      busy_n         = busy;
      unique case (state)
         IDLE: begin
            if (reqValid) begin
               state_n     = ACCESS;
               base_n      = reqAddr;
               size_n      = reqSize;
               sgn_n       = reqSigned;
               wr_n        = reqWrite;
               err_n       = misaligned;
               last_n      = req_last;
               idx_n       = 2'd0;
               busy_n      = 1'b1;
               data_n      = reqWrite ? reqWData : 32'h0;
               mem_addr_n  = reqAddr;
               mem_read_n  = !reqWrite && !misaligned;
               mem_write_n = reqWrite && !misaligned;
               mem_wdata_n = reqWrite ? byte_of(reqWData, req_last) : 8'h00;
            end
         end
         ACCESS: begin
            if (err) begin
               state_n        = DONE;
               resp_valid_n   = 1'b1;
               misalign_err_n = 1'b1;
               resp_data_n    = 32'h0;
            end else if (memReady) begin
               if (!wr) data_n = assembled;
               if (idx == last) begin
                  state_n      = DONE;
                  mem_read_n   = 1'b0;
                  mem_write_n  = 1'b0;
                  resp_valid_n = 1'b1;
                  resp_data_n  = wr ? 32'h0 : extend(assembled, size, sgn);
               end else begin
                  idx_n       = idx_inc;
                  mem_addr_n  = base + ADDR_W'(idx_inc);
                  mem_wdata_n = wr ? byte_of(data, last - idx_inc) : 8'h00;
               end
            end
         end
         DONE: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!resetN) begin
         state       <= IDLE;
         base        <= '0;
         data        <= '0;
         size        <= '0;
         sgn         <= 1'b0;
         wr          <= 1'b0;
         err         <= 1'b0;
         last        <= '0;
         idx         <= '0;
         memAddr     <= '0;
         memRead     <= 1'b0;
         memWrite    <= 1'b0;
         memWData    <= '0;
         respValid   <= 1'b0;
         respData    <= '0;
         misalignErr <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         base        <= base_n;
         data        <= data_n;
         size        <= size_n;
         sgn         <= sgn_n;
         wr          <= wr_n;
         err         <= err_n;
         last        <= last_n;
         idx         <= idx_n;
         memAddr     <= mem_addr_n;
         memRead     <= mem_read_n;
         memWrite    <= mem_write_n;
         memWData    <= mem_wdata_n;
         respValid   <= resp_valid_n;
         respData    <= resp_data_n;
         misalignErr <= misalign_err_n;
         busy        <= busy_n;
      end
   end
endmodule
